// File: rtl/ring_seq_gen.sv
// ---------------------------------------------------------------------------
// ring_seq_gen
//   One-hot ring / Johnson sequence generator with a programmable step
//   prescaler, direction control, validated parallel load, self-correction
//   of illegal states, and single-cycle step / wrap / error strobes.
//
// Parameters
//   WIDTH     number of sequence bits (>= 2)
//   SEED_POS  bit index that is set in the ring-mode seed
//   DIV_W     prescaler width
//
// Ports
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   en        advance enable; the prescaler only counts while en=1
//   dir       0: shift up (bit i -> i+1), 1: shift down
//   mode      0: ring (one-hot), 1: Johnson (thermometer)
//   load      parallel load strobe
//   load_val  value to load (rejected and reseeded if illegal for mode)
//   div       advance once every div+1 enabled cycles
//   q         registered sequence state
//   step      pulse in the cycle q shows an advanced value
//   wrap      pulse in the cycle q returns to the seed through an advance
//   err       pulse in the cycle q shows a corrected / rejected value
// ---------------------------------------------------------------------------
module ring_seq_gen #(
    parameter int WIDTH    = 6,
    parameter int SEED_POS = 3,
    parameter int DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] SEED_R = {{(WIDTH-1){1'b0}}, 1'b1} << SEED_POS;
    localparam logic [WIDTH-1:0] SEED_J = '0;

    logic [WIDTH-1:0] q_reg, q_next;
    logic             mode_reg, mode_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] ring_up, ring_dn, john_up, john_dn;
    logic [WIDTH-1:0] adv_q;
    logic [WIDTH-1:0] seed_sel;
    logic             adv;

    // Ring: exactly one bit set. Johnson: a run of ones anchored at either end
    // (low-side run, or its complement is a low-side run), which also covers
    // all-zeros and all-ones.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
        logic [WIDTH-1:0] nv;
        nv = ~v;
        if (m)
            is_legal = ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
        else
            is_legal = ($countones(v) == 1);
    endfunction

    // Per-bit shift networks for both modes and directions.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign ring_up[gi] = q_reg[WIDTH-1];
                assign john_up[gi] = ~q_reg[WIDTH-1];
            end else begin : g_up
                assign ring_up[gi] = q_reg[gi-1];
                assign john_up[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign ring_dn[gi] = q_reg[0];
                assign john_dn[gi] = ~q_reg[0];
            end else begin : g_dn
                assign ring_dn[gi] = q_reg[gi+1];
                assign john_dn[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        case ({mode_reg, dir})
            2'b00:   adv_q = ring_up;
            2'b01:   adv_q = ring_dn;
            2'b10:   adv_q = john_up;
            default: adv_q = john_dn;
        endcase
    end

    // Seed follows the requested mode; in every branch that uses it below
    // except the mode switch, mode already equals mode_reg.
    assign seed_sel = mode ? SEED_J : SEED_R;
    assign adv      = en && (cnt_reg == div);

    always_comb begin
        q_next    = q_reg;
        mode_next = mode_reg;
        cnt_next  = en ? cnt_reg + DIV_W'(1) : cnt_reg;
        step_next = 1'b0;
        wrap_next = 1'b0;
        err_next  = 1'b0;

        if (mode != mode_reg) begin
            mode_next = mode;
            q_next    = seed_sel;
            cnt_next  = '0;
        end else if (load) begin
            // Load takes priority over a coincident advance.
            cnt_next = '0;
            if (is_legal(load_val, mode)) begin
                q_next = load_val;
            end else begin
                q_next   = seed_sel;
                err_next = 1'b1;
            end
        end else if (!is_legal(q_reg, mode_reg)) begin
            q_next   = seed_sel;
            err_next = 1'b1;
            cnt_next = '0;
        end else if (adv) begin
            q_next    = adv_q;
            step_next = 1'b1;
            wrap_next = (adv_q == seed_sel);
            cnt_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg    <= SEED_R;
            mode_reg <= 1'b0;
            cnt_reg  <= '0;
            step_reg <= 1'b0;
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            mode_reg <= mode_next;
            cnt_reg  <= cnt_next;
            step_reg <= step_next;
            wrap_reg <= wrap_next;
            err_reg  <= err_next;
        end
    end

    assign q    = q_reg;
    assign step = step_reg;
    assign wrap = wrap_reg;
    assign err  = err_reg;

endmodule
